// File: rtl/insn_buffer_ctrl.sv
// Instruction buffer between fetch and decode: assembles 16-bit parcels into 16/32-bit instructions.
// Define RAFI_RVC_EN to enable compressed (16-bit) instruction detection.
package insn_buffer_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] insn_t;

  localparam int INSN_BUFFER_ENTRY_COUNT = 4;
  typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT):0] insn_buffer_entry_count_t;

  typedef enum logic [3:0] {
    InsnAddrMisaligned = 4'd0,
    InsnAccessFault    = 4'd1,
    IllegalInsn        = 4'd2
  } ExceptionCode;

  typedef struct packed {
    logic         valid;
    ExceptionCode cause;
    addr_t        value;
  } TrapInfo;

  typedef struct packed {
    addr_t       pc;
    logic        fault;
    logic [15:0] insn;
  } InsnBufferEntry;
endpackage

module insn_buffer_ctrl
  import insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_valid,
  input  logic [1:0]                   push_count,
  input  InsnBufferEntry               push_entry0,
  input  InsnBufferEntry               push_entry1,
  output logic                         push_ready,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output addr_t                        pop_pc,
  output insn_t                        pop_insn,
  output logic                         pop_compressed,
  output TrapInfo                      pop_trap,
  output logic [$clog2(ENTRY_COUNT):0] count
);
  localparam int PW = $clog2(ENTRY_COUNT);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    TRAP_WAIT = 1'b1
  } state_t;

  InsnBufferEntry entries_r [ENTRY_COUNT];
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [CW-1:0]  count_r;
  state_t         state_r;
  state_t         state_next_s;

  InsnBufferEntry head_entry_s;
  InsnBufferEntry next_entry_s;
  logic           is_32_s;
  logic [1:0]     need_s;
  logic           trap_s;
  addr_t          trap_value_s;
  logic           has_need_s;
  logic [1:0]     push_n_s;
  logic           push_fire_s;
  logic           pop_fire_s;
  logic [CW-1:0]  push_add_s;
  logic [CW-1:0]  pop_sub_s;

  assign head_entry_s = entries_r[head_r];
  assign next_entry_s = entries_r[head_r + PW'(1)];

  // Classify the head: parcels needed, and whether the instruction is a fetch trap.
  always_comb begin
`ifdef RAFI_RVC_EN
    is_32_s = (head_entry_s.insn[1:0] == 2'b11);
`else
    is_32_s = 1'b1;
`endif
    if (head_entry_s.fault) begin
      need_s       = 2'd1;
      trap_s       = 1'b1;
      trap_value_s = head_entry_s.pc;
    end else if (is_32_s) begin
      need_s       = 2'd2;
      trap_s       = next_entry_s.fault;
      trap_value_s = next_entry_s.pc;
    end else begin
      need_s       = 2'd1;
      trap_s       = 1'b0;
      trap_value_s = head_entry_s.pc;
    end
  end

  assign has_need_s = (count_r >= CW'(need_s));
  // Only free slots at the start of the cycle count; a same-cycle pop does not help.
  assign push_ready  = (count_r <= CW'(ENTRY_COUNT - 2));
  assign push_n_s    = (push_count == 2'd2) ? 2'd2 : 2'd1;
  assign push_fire_s = push_valid && push_ready && !flush;
  assign pop_fire_s  = pop_valid && pop_ready;
  assign count       = count_r;

  // Handshake-qualified occupancy deltas.
  always_comb begin
    if (push_fire_s) begin
      push_add_s = CW'(push_n_s);
    end else begin
      push_add_s = '0;
    end
    if (pop_fire_s) begin
      pop_sub_s = CW'(need_s);
    end else begin
      pop_sub_s = '0;
    end
  end

  // Decode-facing outputs, combinational from held parcels and gated by flush.
  always_comb begin
    pop_valid = (state_r == NORMAL) && !flush && has_need_s;
    pop_pc    = head_entry_s.pc;
    if (is_32_s) begin
      pop_insn = {next_entry_s.insn, head_entry_s.insn};
    end else begin
      pop_insn = {16'h0000, head_entry_s.insn};
    end
`ifdef RAFI_RVC_EN
    pop_compressed = !is_32_s;
`else
    pop_compressed = 1'b0;
`endif
    pop_trap.valid = trap_s && has_need_s;
    pop_trap.cause = InsnAccessFault;
    pop_trap.value = trap_value_s;
  end

  // Pointer and occupancy registers; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_fire_s) begin
        tail_r <= tail_r + PW'(push_n_s);
      end
      if (pop_fire_s) begin
        head_r <= head_r + PW'(need_s);
      end
      count_r <= count_r + push_add_s - pop_sub_s;
    end
  end

  // Parcel storage; the second parcel lands at tail+1 with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        entries_r[i] <= '0;
      end
    end else if (push_fire_s) begin
      entries_r[tail_r] <= push_entry0;
      if (push_n_s == 2'd2) begin
        entries_r[tail_r + PW'(1)] <= push_entry1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= NORMAL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: a popped trap halts issue until the pipeline flushes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      NORMAL: begin
        if (flush) begin
          state_next_s = NORMAL;
        end else if (pop_fire_s && trap_s) begin
          state_next_s = TRAP_WAIT;
        end else begin
          state_next_s = NORMAL;
        end
      end
      TRAP_WAIT: begin
        if (flush) begin
          state_next_s = NORMAL;
        end else begin
          state_next_s = TRAP_WAIT;
        end
      end
      default: state_next_s = NORMAL;
    endcase
  end
endmodule
